// File: rtl/window_read_ctrl.sv
// Pointer and flow controller for a circular sample buffer: write pointer, read
// pointer and occupancy tracking, plus a job FSM that streams strided read windows.
module window_read_ctrl #(
    parameter int unsigned SIZE       = 8,
    parameter int unsigned WRITE_SIZE = 2,
    parameter int unsigned READ_SIZE  = 2,
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned CNT_WIDTH  = 8,
    localparam int unsigned PW        = $clog2(SIZE),
    localparam int unsigned SW        = $clog2(READ_SIZE) + 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            in_valid_i,
    output logic                            in_ready_o,
    output logic                            buf_wr_en_o,
    output logic [PW-1:0]                   buf_wr_addr_o,
    output logic [PW-1:0]                   buf_rd_addr_o,
    input  logic [READ_SIZE*DATA_WIDTH-1:0] buf_rd_data_i,
    input  logic                            start_i,
    input  logic [CNT_WIDTH-1:0]            num_windows_i,
    input  logic [SW-1:0]                   stride_i,
    output logic                            out_valid_o,
    input  logic                            out_ready_i,
    output logic [READ_SIZE*DATA_WIDTH-1:0] out_data_o,
    output logic                            busy_o,
    output logic                            done_o
);

    localparam int unsigned OW = PW + 1;

    localparam logic [OW-1:0] OCC_PUSH_LIM = OW'(SIZE - WRITE_SIZE);
    localparam logic [OW-1:0] OCC_WR_STEP  = OW'(WRITE_SIZE);
    localparam logic [OW-1:0] OCC_RD_MIN   = OW'(READ_SIZE);
    localparam logic [PW-1:0] PTR_WR_STEP  = PW'(WRITE_SIZE);
    localparam logic [SW-1:0] STRIDE_MAX   = SW'(READ_SIZE);
    localparam logic [SW-1:0] STRIDE_MIN   = SW'(1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_e;

    state_e               state_q,  state_d;
    logic [PW-1:0]        wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]        rd_ptr_q, rd_ptr_d;
    logic [OW-1:0]        occ_q,    occ_d;
    logic [CNT_WIDTH-1:0] remain_q, remain_d;
    logic [SW-1:0]        stride_q, stride_d;

    logic                 push;
    logic                 pop;
    logic [SW-1:0]        stride_clamped;

    // Zero stride would stall the job; oversize stride would skip unread words.
    always_comb begin
        stride_clamped = stride_i;
        if (stride_i == '0) begin
            stride_clamped = STRIDE_MIN;
        end else if (stride_i > STRIDE_MAX) begin
            stride_clamped = STRIDE_MAX;
        end
    end

    // Write side only looks at registered occupancy, so a same-cycle pop never opens a slot.
    assign in_ready_o    = (occ_q <= OCC_PUSH_LIM);
    assign push          = in_valid_i & in_ready_o;
    assign buf_wr_en_o   = push;
    assign buf_wr_addr_o = wr_ptr_q;
    assign buf_rd_addr_o = rd_ptr_q;
    assign out_data_o    = buf_rd_data_i;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            occ_q    <= '0;
            remain_q <= '0;
            stride_q <= STRIDE_MIN;
        end else begin
            state_q  <= state_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            occ_q    <= occ_d;
            remain_q <= remain_d;
            stride_q <= stride_d;
        end
    end

    // Job sequencing, read handshake and pointer/occupancy bookkeeping.
    always_comb begin
        state_d     = state_q;
        remain_d    = remain_q;
        stride_d    = stride_q;
        out_valid_o = 1'b0;
        busy_o      = 1'b0;
        done_o      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    stride_d = stride_clamped;
                    remain_d = num_windows_i;
                    state_d  = (num_windows_i == '0) ? S_DONE : S_RUN;
                end
            end
            S_RUN: begin
                busy_o      = 1'b1;
                out_valid_o = (occ_q >= OCC_RD_MIN);
            end
            S_DONE: begin
                busy_o  = 1'b1;
                done_o  = 1'b1;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        pop = out_valid_o & out_ready_i;

        if (pop) begin
            remain_d = remain_q - CNT_WIDTH'(1);
            if (remain_q == CNT_WIDTH'(1)) begin
                state_d = S_DONE;
            end
        end

        wr_ptr_d = push ? (wr_ptr_q + PTR_WR_STEP) : wr_ptr_q;
        rd_ptr_d = pop  ? (rd_ptr_q + PW'(stride_q)) : rd_ptr_q;
        occ_d    = occ_q + (push ? OCC_WR_STEP : '0) - (pop ? OW'(stride_q) : '0);
    end

endmodule

// File: doc/window_read_ctrl.md
# window_read_ctrl

Pointer and flow controller for the circular sample buffer. It owns the buffer's write pointer and read pointer and tracks how many words the buffer holds. Upstream pushes arrive through a valid/ready handshake, and each push is forwarded to the buffer as a write of WRITE_SIZE words. On the read side, the block presents READ_SIZE-word windows to the downstream processing element and advances the read pointer by a programmable stride. The block sits between the input stream and the buffer on the write side, and between the buffer and the PE array on the read side.

## Interface
Parameters:
- SIZE, 8, buffer depth in words; power of two, ≥ 2·WRITE_SIZE.
- WRITE_SIZE, 2, words written per accepted push.
- READ_SIZE, 2, words per window; ≤ SIZE.
- DATA_WIDTH, 8, bits per word.
- CNT_WIDTH, 8, width of the window count.

Ports (PW = $clog2(SIZE), SW = $clog2(READ_SIZE)+1):
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  upstream has WRITE_SIZE words ready.
- in_ready  out  1  buffer can accept a push.
- buf_wr_en  out  1  buffer write strobe; equals in_valid & in_ready.
- buf_wr_addr  out  PW  buffer slot for word 0 of the push; equals wr_ptr.
- buf_rd_addr  out  PW  buffer slot for window word 0; equals rd_ptr.
- buf_rd_data  in  READ_SIZE×DATA_WIDTH  window words from the buffer, valid in the same cycle as the address.
- start  in  1  one-cycle pulse that launches a job; sampled only in IDLE.
- num_windows  in  CNT_WIDTH  number of windows in the job; latched on start.
- stride  in  SW  read-pointer advance per window; latched on start.
- out_valid  out  1  window available.
- out_ready  in  1  downstream accepts the window.
- out_data  out  READ_SIZE×DATA_WIDTH  window contents; passthrough of buf_rd_data.
- busy  out  1  high in RUN and DONE.
- done  out  1  one-cycle pulse at job end.

## Operation
State and widths:
- Registers: wr_ptr (PW bits), rd_ptr (PW bits), occ (PW+1 bits, range 0..SIZE), FSM state, remaining-window counter, latched stride.
- Pointer arithmetic is modulo SIZE; natural PW-bit wrap.

Write side:
- in_ready = (occ ≤ SIZE−WRITE_SIZE). This uses the registered occ only; a pop in the same cycle does not raise it.
- push = in_valid & in_ready. On push, wr_ptr advances by WRITE_SIZE.
- Pushes are accepted in every FSM state.

Read side:
- out_valid = (state==RUN) & (occ ≥ READ_SIZE).
- pop = out_valid & out_ready. On pop, rd_ptr advances by the latched stride and the remaining count decrements.
- Occupancy update: occ_next = occ + (push ? WRITE_SIZE : 0) − (pop ? stride : 0). Simultaneous push and pop apply both terms.

Stride latch:
- stride = 0 is latched as 1.
- stride > READ_SIZE is latched as READ_SIZE.
- This clamping guarantees occ ≥ stride whenever a pop occurs.

FSM:
- IDLE: on start, latch num_windows and stride. Go to RUN if num_windows ≠ 0, otherwise go to DONE.
- RUN: when a pop occurs with remaining==1, go to DONE.
- DONE: assert done for one cycle, then go to IDLE.
- Leftover occupancy and both pointers persist across jobs. Overlap data stays available for the next job.

Reset values (next edge after rst=1): wr_ptr=0, rd_ptr=0, occ=0, state IDLE, out_valid=0, done=0, busy=0, in_ready=1, buf_wr_en=0. A reset asserted mid-job abandons the job without a done pulse.

## Timing
- Zero-cycle read latency: out_data combinationally follows buf_rd_data at buf_rd_addr=rd_ptr.
- While out_valid=1 and out_ready=0: rd_ptr, out_valid and out_data hold stable. No push can overwrite an unread slot, because in_ready guards occupancy.
- Throughput: one window per cycle when occ ≥ READ_SIZE; one push per cycle when not full.
- done rises exactly one cycle after the final pop, or one cycle after a start with num_windows=0.
- start while busy is ignored.

## Test plan
All scenarios use default parameters.
- Fill: after reset, hold in_valid=1 for 5 cycles with no start. Required: buf_wr_addr = 0,2,4,6 on the first four cycles, occ=8, in_ready=0 after the 4th push, and buf_wr_en=0 on the 5th cycle.
- Stride-1 job: buffer holds words 0..7 (occ=8); start with num_windows=3, stride=1, out_ready=1. Required: windows {0,1},{1,2},{2,3} on consecutive cycles with buf_rd_addr 0,1,2, a done pulse on the next cycle, then occ=5 and rd_ptr=3.
- Backpressure: during a job, drop out_ready for 3 cycles. Required: out_valid stays 1, buf_rd_addr and out_data stay constant, no count decrement, and the job resumes on the cycle out_ready returns.
- Wrap and simultaneous events: stride=2 with continuous push and pop. Required: rd_ptr and wr_ptr wrap 6→0, and occ stays constant on every cycle where push and pop coincide.
- Edge inputs: start with num_windows=0 gives done the next cycle with no out_valid. start with stride=0 and num_windows=2 advances rd_ptr by 1 per window.
- Reset mid-RUN: assert rst after 1 of 4 windows. Required: all reset values on the next edge, no done pulse, and a subsequent fill starts at buf_wr_addr=0.
